icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, fetch/memory address width in bits.
REQ-002 Parameter DATA_W, 32, instruction word and memory beat width.
REQ-003 Parameter LINE_WORDS, 4, words per cache line; power of two, >=2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  fetch stage presents a fetch this cycle.
REQ-007 req_addr  input  ADDR_W  fetch byte address, word aligned.
REQ-008 hit  input  1  tag-compare result for req_addr, same cycle.
REQ-009 stall  output  1  pipeline stall; drives the active-low en of the downstream jump-delay stage.
REQ-010 mem_req  output  1  line-read request to memory.
REQ-011 mem_addr  output  ADDR_W  line-aligned read address.
REQ-012 mem_gnt  input  1  memory accepts request when mem_req && mem_gnt.
REQ-013 mem_rvalid  input  1  one read beat valid.
REQ-014 mem_rdata  input  DATA_W  read beat data.
REQ-015 fill_we  output  1  write one word into the data array.
REQ-016 fill_idx  output  log2(LINE_WORDS)  word offset within line.
REQ-017 fill_data  output  DATA_W  word to write (mem_rdata, combinational pass-through).
REQ-018 tag_we  output  1  write line tag and set valid.
REQ-019 line_addr  output  ADDR_W  latched line address for tag/index write.
REQ-020 miss_cnt  output  16  saturating count of refills started.

Function
REQ-021 FSM states IDLE, REQ, FILL, UPDATE; encoding from shared package.
REQ-022 IDLE: req_valid && !hit -> latch line_addr = req_addr with low log2(LINE_WORDS)+2 bits zeroed, go REQ; otherwise stay.
REQ-023 REQ: mem_req=1, mem_addr=line_addr; stay until mem_gnt=1, then go FILL with beat counter=0.
REQ-024 FILL: each mem_rvalid=1 cycle -> fill_we=1, fill_idx=beat counter, counter+1; on beat LINE_WORDS-1 go UPDATE.
REQ-025 UPDATE: tag_we=1 for exactly one cycle, then IDLE.
REQ-026 stall = (state != IDLE) || (state == IDLE && req_valid && !hit); combinational, asserted in the miss-detection cycle.
REQ-027 Minimum miss penalty with mem_gnt in first REQ cycle and back-to-back beats: stall high 1 + 1 + LINE_WORDS + 1 cycles; refetch hits in following IDLE cycle.
REQ-028 mem_req held high and mem_addr stable in REQ until grant; no second request per refill.
REQ-029 mem_rvalid outside FILL ignored: no fill_we, no counter change.
REQ-030 fill_we, tag_we, mem_req are 0 in every state other than FILL (with rvalid), UPDATE, REQ respectively.
REQ-031 req_valid/hit changes during REQ/FILL/UPDATE ignored; refill always completes to UPDATE.
REQ-032 miss_cnt increments by 1 on each IDLE->REQ transition; holds at 16'hFFFF.
REQ-033 Beat counter wraps to 0 on entry to FILL; never exceeds LINE_WORDS-1.

Reset
REQ-034 rst=1 forces, asynchronously: state IDLE, beat counter 0, line_addr 0, miss_cnt 0.
REQ-035 During/after reset, registered outputs 0; stall, mem_req, fill_we, tag_we 0 unless IDLE miss condition holds after rst deasserts.
REQ-036 Reset mid-refill abandons the line: no tag_we; stray mem_rvalid beats afterwards ignored per REQ-029.

Structure
REQ-037 Shared package icache_pkg holds state enum, LINE_WORDS default, OFFSET_W = log2(LINE_WORDS), BYTE_OFF_W = 2.
REQ-038 One sub-module, icache_fill_counter: beat counter with clear, increment, last-beat flag.

Verification
REQ-039 Hit: req_valid=1, hit=1 -> stall=0, mem_req=0, miss_cnt unchanged.
REQ-040 Miss at 0x0000_1234, gnt immediate, 4 back-to-back beats D0..D3 -> mem_addr=0x0000_1230, fill_idx 0,1,2,3 with D0..D3, tag_we one cycle, stall high 7 cycles, miss_cnt=1.
REQ-041 Miss with mem_gnt delayed 3 cycles and rvalid gaps of 2 cycles -> mem_req held 4 cycles, addr stable, exactly 4 fill_we pulses, stall high throughout.
REQ-042 Spurious mem_rvalid in IDLE and REQ -> no fill_we, counter unchanged.
REQ-043 rst asserted after beat 2 -> immediate IDLE, stall=0, no tag_we; next miss refills cleanly from fill_idx 0.
REQ-044 Force miss_cnt to 16'hFFFE, two misses -> reads 16'hFFFF, stays.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill path: FSM states and line geometry.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned OFFSET_W       = $clog2(LINE_WORDS_DEF);
    localparam int unsigned BYTE_OFF_W     = 2;

endpackage

// File: rtl/icache_fill_counter.sv
// Beat counter for a line refill: synchronous clear, increment, and last-beat flag.
module icache_fill_counter #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          inc,
    output logic [$clog2(LINE_WORDS)-1:0] cnt,
    output logic                          last
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    // Power-of-two line length lets the increment wrap naturally after the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: detects a miss, requests the line, writes beats, then the tag.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          hit,
    output logic                          stall,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]             fill_data,
    output logic                          tag_we,
    output logic [ADDR_W-1:0]             line_addr,
    output logic [15:0]                   miss_cnt
);

    localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
    localparam int unsigned LOW_W  = IDX_W + BYTE_OFF_W;

    state_t             state;
    state_t             state_nxt;
    logic               miss;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               cnt_last;
    logic [IDX_W-1:0]   cnt;

    assign miss = req_valid && !hit;

    icache_fill_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_fill_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_req   = 1'b0;
        fill_we   = 1'b0;
        tag_we    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (miss) begin
                    stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt) begin
                    cnt_clr   = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    fill_we = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_nxt = UPDATE;
                    end
                end
            end
            UPDATE: begin
                stall     = 1'b1;
                tag_we    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_addr <= '0;
            miss_cnt  <= '0;
        end else if (state == IDLE && miss) begin
            line_addr <= {req_addr[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
            if (miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign mem_addr  = line_addr;
    assign fill_idx  = cnt;
    assign fill_data = mem_rdata;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed-plus-random bench for icache_refill_ctrl against a transaction-level reference.
module tb_icache_refill_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              hit;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              fill_we;
    logic [1:0]        fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              tag_we;
    logic [ADDR_W-1:0] line_addr;
    logic [15:0]       miss_cnt;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [15:0] exp_cnt;

    icache_refill_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .hit        (hit),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_idx   (fill_idx),
        .fill_data  (fill_data),
        .tag_we     (tag_we),
        .line_addr  (line_addr),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: line base is the byte address rounded down to a 16-byte multiple.
    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return (a / (LW * 4)) * (LW * 4);
    endfunction

    function automatic logic [15:0] bump(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // One full refill. Inputs change at negedge; outputs checked 1 time unit later.
    task automatic refill(input logic [ADDR_W-1:0] addr, input int unsigned gnt_dly,
                          input int unsigned gap, input bit noise);
        logic [DATA_W-1:0] beats[$];
        logic [ADDR_W-1:0] exp_line;
        int unsigned       stall_cycles;
        int unsigned       we_pulses;
        exp_line     = line_of(addr);
        stall_cycles = 0;
        we_pulses    = 0;
        for (int i = 0; i < int'(LW); i++) beats.push_back($urandom());

        req_valid = 1'b1; hit = 1'b0; req_addr = addr; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("miss_detect_stall", stall, 1);
        check("miss_detect_memreq", mem_req, 0);
        stall_cycles += stall;
        @(negedge clk);
        exp_cnt = bump(exp_cnt);

        for (int d = 0; d <= int'(gnt_dly); d++) begin
            req_valid  = noise ? 1'($urandom()) : 1'b0;
            hit        = noise ? 1'($urandom()) : 1'b0;
            req_addr   = $urandom();
            mem_gnt    = (d == int'(gnt_dly));
            mem_rvalid = noise ? 1'($urandom()) : 1'b0;
            #1;
            check("req_memreq", mem_req, 1);
            check("req_addr", mem_addr, exp_line);
            check("req_no_fill", fill_we, 0);
            stall_cycles += stall;
            @(negedge clk);
        end
        check("miss_cnt", miss_cnt, exp_cnt);
        check("line_addr", line_addr, exp_line);
        mem_gnt = 1'b0;

        for (int b = 0; b < int'(LW); b++) begin
            for (int g = 0; g < int'(gap); g++) begin
                mem_rvalid = 1'b0;
                req_valid  = noise ? 1'($urandom()) : 1'b0;
                #1;
                check("gap_no_fill", fill_we, 0);
                stall_cycles += stall;
                @(negedge clk);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beats[b];
            #1;
            check("fill_we", fill_we, 1);
            check("fill_idx", fill_idx, b);
            check("fill_data", fill_data, beats[b]);
            check("fill_no_tag", tag_we, 0);
            check("fill_no_req", mem_req, 0);
            we_pulses += fill_we;
            stall_cycles += stall;
            @(negedge clk);
        end
        check("fill_pulses", we_pulses, LW);

        mem_rvalid = 1'b0;
        #1;
        check("update_tag_we", tag_we, 1);
        check("update_no_fill", fill_we, 0);
        stall_cycles += stall;
        @(negedge clk);
        check("stall_cycles", stall_cycles, 1 + (gnt_dly + 1) + LW * (gap + 1) + 1);

        req_valid = 1'b1; hit = 1'b1; req_addr = addr;
        #1;
        check("refetch_stall", stall, 0);
        check("refetch_tag_we", tag_we, 0);
        check("refetch_memreq", mem_req, 0);
        @(negedge clk);
        req_valid = 1'b0; hit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; hit = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_line_addr", line_addr, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Hits never stall or request.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; hit = 1'b1; req_addr = $urandom() & 32'hFFFF_FFFC;
            #1;
            check("hit_stall", stall, 0);
            check("hit_memreq", mem_req, 0);
            @(negedge clk);
            check("hit_miss_cnt", miss_cnt, exp_cnt);
        end

        // Stray beats in IDLE.
        req_valid = 1'b0; hit = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom();
        #1;
        check("idle_stray_fill", fill_we, 0);
        check("idle_stray_stall", stall, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        refill(32'h0000_1234, 0, 0, 1'b0);
        refill(32'h0000_ABC8, 3, 2, 1'b1);
        for (int i = 0; i < 4; i++)
            refill($urandom() & 32'hFFFF_FFFC, $urandom_range(0, 4), $urandom_range(0, 2), 1'b1);

        // Reset after beat 2 abandons the line.
        req_valid = 1'b1; hit = 1'b0; req_addr = 32'h0000_5678;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom();
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_tag_we", tag_we, 0);
        check("midrst_fill_we", fill_we, 0);
        check("midrst_miss_cnt", miss_cnt, 0);
        check("midrst_addr", mem_addr, 0);
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_stray_fill", fill_we, 0);
        check("postrst_tag_we", tag_we, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        refill(32'h0000_9ABC, 1, 0, 1'b0);

        // Saturation of the miss counter.
        force dut.miss_cnt = 16'hFFFE;
        #1;
        release dut.miss_cnt;
        exp_cnt = 16'hFFFE;
        check("sat_preload", miss_cnt, 16'hFFFE);
        @(negedge clk);
        refill(32'h0000_2000, 0, 0, 1'b0);
        check("sat_first", miss_cnt, 16'hFFFF);
        refill(32'h0000_3004, 0, 1, 1'b0);
        check("sat_hold", miss_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
